seg7_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for a bank of common-anode 7-segment digits sharing one segment bus.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/hex7seg.sv | 16 +
 rtl/seg7_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment pattern table for the 7-segment scan logic.
// Segment bytes are {dp,g,f,e,d,c,b,a}, active low; dp is always off.
package seg7_pkg;

  typedef logic [7:0] seg_t;

  typedef struct packed {
    logic       on;
    logic [3:0] val;
  } digit_t;

  localparam seg_t SEG_BLANK = 8'hFF;

  localparam seg_t SEG_HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex digit to 7-segment pattern lookup (active low, dp off).
// Ports:
//   val  in   4-bit hex value
//   seg  out  segment pattern {dp,g,f,e,d,c,b,a}
module hex7seg
  import seg7_pkg::*;
(
  input  logic [3:0] val,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_HEX[val];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits on a shared
// segment bus. Host writes a shadow register file; a commit copies it to the
// active file at the next frame end so a frame never mixes old and new values.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   wr_valid/wr_ready     shadow write handshake (wr_idx, wr_val, wr_on)
//   commit                pulse: copy shadow to active at next frame end
//   frame_done            registered pulse, cycle after each frame end
//   an                    anode selects, active low
//   seg                   segments {dp,g,f,e,d,c,b,a}, active low
//
// state    | meaning
// ST_BLANK | first BLANK_CYCLES of a slot, all anodes off
// ST_SHOW  | rest of the slot, current digit driven
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DIV_CYCLES   = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [2:0]            wr_idx,
  input  logic [3:0]            wr_val,
  input  logic                  wr_on,
  input  logic                  commit,
  output logic                  frame_done,
  output logic [NUM_DIGITS-1:0] an,
  output seg_t                  seg
);

  localparam int CW = $clog2(DIV_CYCLES);
  localparam int DW = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0]         CNT_LAST  = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0]         BLANK_LIM = CW'(BLANK_CYCLES);
  localparam logic [DW-1:0]         DIG_LAST  = DW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DW-1:0]           dig_q, dig_d;
  logic                    slot_end, frame_end;
  logic                    pending_q;
  logic                    wr_hit;
  digit_t                  shadow [NUM_DIGITS];
  digit_t                  active [NUM_DIGITS];
  digit_t                  cur;
  seg_t                    dec_seg;
  seg_t                    seg_d;
  logic [NUM_DIGITS-1:0]   an_d;

  assign cur      = active[dig_q];
  assign wr_ready = ~pending_q;
  assign wr_hit   = wr_valid & wr_ready & (int'(wr_idx) < NUM_DIGITS);

  hex7seg u_dec (
    .val (cur.val),
    .seg (dec_seg)
  );

  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (dig_q == DIG_LAST);
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    dig_d     = dig_q;
    if (slot_end) begin
      dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
    end
    state_d = (cnt_d < BLANK_LIM) ? ST_BLANK : ST_SHOW;

    an_d  = '1;
    seg_d = SEG_BLANK;
    case (state_q)
      ST_SHOW: begin
        an_d = ~(AN_ONE << dig_q);
        if (cur.on) begin
          seg_d = dec_seg;
        end
      end
      default: begin
        an_d  = '1;
        seg_d = SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an         <= '1;
      seg        <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      an         <= an_d;
      seg        <= seg_d;
      frame_done <= frame_end;
    end
  end

  // A commit arriving while one is pending is ignored; the copy at frame end
  // uses the shadow as it stood before that edge (writes are blocked anyway).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (wr_hit) begin
        shadow[wr_idx[DW-1:0]] <= '{on: wr_on, val: wr_val};
      end
      if (frame_end && pending_q) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          active[i] <= shadow[i];
        end
        pending_q <= 1'b0;
      end else if (commit && !pending_q) begin
        pending_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int DV = 4;
  localparam int BL = 1;
  localparam int FR = ND * DV;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [2:0]    wr_idx = '0;
  logic [3:0]    wr_val = '0;
  logic          wr_on = 1'b0;
  logic          commit = 1'b0;
  logic          frame_done;
  logic [ND-1:0] an;
  logic [7:0]    seg;

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .DIV_CYCLES(DV), .BLANK_CYCLES(BL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_idx     (wr_idx),
    .wr_val     (wr_val),
    .wr_on      (wr_on),
    .commit     (commit),
    .frame_done (frame_done),
    .an         (an),
    .seg        (seg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] hex_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: outputs follow from the cycle number since reset release.
  logic       m_valid = 1'b0;
  int         t = 0;
  logic       m_pend;
  logic       sh_on [ND];
  logic [3:0] sh_val [ND];
  logic       ac_on [ND];
  logic [3:0] ac_val [ND];
  logic [3:0] exp_an;
  logic [7:0] exp_seg;
  logic       exp_fd;
  logic       exp_rdy;

  always @(posedge clk) begin
    if (!rst_n) begin
      t = 0;
      m_pend = 1'b0;
      for (int i = 0; i < ND; i++) begin
        sh_on[i] = 1'b0; sh_val[i] = 4'h0; ac_on[i] = 1'b0; ac_val[i] = 4'h0;
      end
      exp_an = 4'hF; exp_seg = 8'hFF; exp_fd = 1'b0; exp_rdy = 1'b1;
      m_valid = 1'b1;
    end else begin
      int ph;
      int slot;
      logic [3:0] one;
      one  = 4'b0001;
      ph   = t % DV;
      slot = (t / DV) % ND;
      if (ph < BL) begin
        exp_an = 4'hF; exp_seg = 8'hFF;
      end else begin
        exp_an  = ~(one << slot);
        exp_seg = ac_on[slot] ? hex_tab[ac_val[slot]] : 8'hFF;
      end
      exp_fd = ((t % FR) == FR - 1);
      if (wr_valid && !m_pend && wr_idx < ND) begin
        sh_on[wr_idx] = wr_on; sh_val[wr_idx] = wr_val;
      end
      if (m_pend && (t % FR) == FR - 1) begin
        for (int i = 0; i < ND; i++) begin
          ac_on[i] = sh_on[i]; ac_val[i] = sh_val[i];
        end
        m_pend = 1'b0;
      end else if (commit && !m_pend) begin
        m_pend = 1'b1;
      end
      exp_rdy = !m_pend;
      t++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_an", 32'(an), 32'(exp_an));
      chk("model_seg", 32'(seg), 32'(exp_seg));
      chk("model_frame_done", 32'(frame_done), 32'(exp_fd));
      chk("model_wr_ready", 32'(wr_ready), 32'(exp_rdy));
    end
  end

  // All drive tasks are entered just after a negedge and return on a negedge.
  task automatic wr(input int idx, input logic [3:0] v, input logic on);
    wr_valid = 1'b1; wr_idx = 3'(idx); wr_val = v; wr_on = on;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  task automatic wr_commit(input int idx, input logic [3:0] v, input logic on);
    wr_valid = 1'b1; wr_idx = 3'(idx); wr_val = v; wr_on = on; commit = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0; commit = 1'b0;
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 64);
    if (frame_done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL frame_done_timeout actual=%0d cycles required=<64", n);
    end
  endtask

  // Called on the frame_done negedge; ends on the next one.
  task automatic show_frame(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    logic [7:0] s [4];
    logic [3:0] a [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    a[0] = 4'hE; a[1] = 4'hD; a[2] = 4'hB; a[3] = 4'h7;
    for (int d = 0; d < 4; d++) begin
      repeat (2) @(negedge clk);
      chk({tag, "_an"}, 32'(an), 32'(a[d]));
      chk({tag, "_seg"}, 32'(seg), 32'(s[d]));
      repeat (2) @(negedge clk);
    end
    chk({tag, "_fd"}, 32'(frame_done), 32'd1);
  endtask

  initial begin
    int n;
    // 1: reset and blank scan
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_rdy", 32'(wr_ready), 32'd1);
    rst_n = 1'b1;
    wait_fd(n);
    chk("first_fd_cycles", 32'(n), 32'd16);
    show_frame("t1", 8'hFF, 8'hFF, 8'hFF, 8'hFF);

    // 2: write 1..4, commit
    wr(0, 4'h1, 1'b1); wr(1, 4'h2, 1'b1); wr(2, 4'h3, 1'b1); wr(3, 4'h4, 1'b1);
    do_commit();
    @(negedge clk);
    chk("t2_rdy_low", 32'(wr_ready), 32'd0);
    wait_fd(n);
    chk("t2_rdy_back", 32'(wr_ready), 32'd1);
    show_frame("t2", 8'hF9, 8'hA4, 8'hB0, 8'h99);

    // 3: uncommitted write stays invisible
    wr(2, 4'hF, 1'b1);
    wait_fd(n);
    repeat (3) show_frame("t3_old", 8'hF9, 8'hA4, 8'hB0, 8'h99);
    do_commit();
    wait_fd(n);
    show_frame("t3_new", 8'hF9, 8'hA4, 8'h8E, 8'h99);

    // 4: commit mid digit-1 slot
    wr(3, 4'h0, 1'b1);
    repeat (5) @(negedge clk);
    do_commit();
    repeat (3) @(negedge clk);
    chk("t4_d2_an", 32'(an), 32'hB);
    chk("t4_d2_seg", 32'(seg), 32'h8E);
    repeat (4) @(negedge clk);
    chk("t4_d3_an", 32'(an), 32'h7);
    chk("t4_d3_old", 32'(seg), 32'h99);
    repeat (2) @(negedge clk);
    chk("t4_fd", 32'(frame_done), 32'd1);
    show_frame("t4_new", 8'hF9, 8'hA4, 8'h8E, 8'hC0);

    // 5: write+commit same cycle, then a redundant commit
    wr_commit(1, 4'h8, 1'b1);
    repeat (3) @(negedge clk);
    do_commit();
    chk("t5_rdy", 32'(wr_ready), 32'd0);
    wait_fd(n);
    chk("t5_no_delay", 32'(n), 32'd11);
    show_frame("t5", 8'hF9, 8'h80, 8'h8E, 8'hC0);

    // 6: reset during digit 2 with commit pending
    wr_commit(0, 4'h5, 1'b1);
    repeat (9) @(negedge clk);
    chk("t6_pre_an", 32'(an), 32'hB);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_an", 32'(an), 32'hF);
    chk("t6_rst_seg", 32'(seg), 32'hFF);
    chk("t6_rst_fd", 32'(frame_done), 32'd0);
    chk("t6_rst_rdy", 32'(wr_ready), 32'd1);
    rst_n = 1'b1;
    wait_fd(n);
    chk("t6_fd_cycles", 32'(n), 32'd16);
    show_frame("t6", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    show_frame("t6b", 8'hFF, 8'hFF, 8'hFF, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
